// File: rtl/serial_src.sv
// Bit-serial responder for the REQ/ACK/DATA pull bundle: buffers host words in a
// small FIFO and returns them LSB first, one bit per four-phase handshake.
module serial_src #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTB,
  input  logic                       WR_VALID,
  output logic                       WR_READY,
  input  logic [WIDTH-1:0]           WR_DATA,
  input  logic                       OUT_REQ,
  output logic                       OUT_ACK,
  output logic                       OUT_DATA,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {IDLE, ACKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [BW-1:0]    bit_idx;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
  assign WR_READY = RSTB && (count != FULL_LEVEL);
  assign push     = WR_VALID && WR_READY;
  assign pop      = (state == ACKED) && !OUT_REQ && (bit_idx == LAST_BIT);
  assign LEVEL    = count;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      bit_idx  <= '0;
      count    <= '0;
      OUT_ACK  <= 1'b0;
      OUT_DATA <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          // The count check also hides a word written this very edge (no bypass).
          if (OUT_REQ && (count != '0)) begin
            OUT_ACK  <= 1'b1;
            OUT_DATA <= mem[rd_ptr][bit_idx];
            state    <= ACKED;
          end
        end
        ACKED: begin
          if (!OUT_REQ) begin
            OUT_ACK  <= 1'b0;
            OUT_DATA <= 1'b0;
            state    <= IDLE;
            bit_idx  <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
